// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - register file writeback merge with pending-load scoreboard and hazard stall
module wb_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int REGNUM     = 32,
  parameter int LQ_DEPTH   = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ex_valid,
  input  logic [REG_ADDR_W-1:0]       ex_rd,
  input  logic [DATA_W-1:0]           ex_data,
  output logic                        ex_ready,
  input  logic                        ld_issue_valid,
  input  logic [REG_ADDR_W-1:0]       ld_issue_rd,
  output logic                        ld_issue_ready,
  input  logic                        ld_rsp_valid,
  input  logic [DATA_W-1:0]           ld_rsp_data,
  output logic                        ld_rsp_ready,
  input  logic [REG_ADDR_W-1:0]       rs1_raddr,
  input  logic [REG_ADDR_W-1:0]       rs2_raddr,
  output logic                        hazard_stall,
  output logic [REG_ADDR_W-1:0]       rd_waddr,
  output logic [DATA_W-1:0]           rd_wdata,
  output logic                        wen,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  // A depth of one still needs a one-bit pointer that simply stays at zero.
  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic [REGNUM-1:0]     pending;
  logic [REGNUM-1:0]     pending_nxt;
  logic [REG_ADDR_W-1:0] lq_mem [LQ_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic                  lq_full;
  logic                  lq_empty;
  logic [REG_ADDR_W-1:0] head_rd;
  logic                  issue_fire;
  logic                  rsp_fire;
  logic                  ex_fire;
  logic                  issue_rd_busy;
  logic                  ex_rd_busy;
  logic                  rs1_hazard;
  logic                  rs2_hazard;

  // Pointer advance with explicit wrap so non-power-of-two slips stay correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(LQ_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign lq_full  = (count == CNT_W'(LQ_DEPTH));
  assign lq_empty = (count == '0);
  assign head_rd  = lq_mem[rd_ptr];
  assign lq_count = count;

  // x0 never blocks: its pending bit is held at zero, but keep the test explicit.
  assign issue_rd_busy = (ld_issue_rd != '0) && pending[ld_issue_rd];
  assign ex_rd_busy    = (ex_rd != '0) && pending[ex_rd];

  assign ld_issue_ready = !lq_full && !issue_rd_busy;
  assign ld_rsp_ready   = !lq_empty;
  // Load data owns the write port when it returns; execute also waits out a WAW on a load.
  assign ex_ready       = !rsp_fire && !ex_rd_busy;

  assign issue_fire = ld_issue_valid && ld_issue_ready;
  assign rsp_fire   = ld_rsp_valid && ld_rsp_ready;
  assign ex_fire    = ex_valid && ex_ready;

  // A source is unsafe while a load owes it data or while its write is still heading to the register file.
  assign rs1_hazard = (rs1_raddr != '0) &&
                      (pending[rs1_raddr] || (wen && (rd_waddr == rs1_raddr)));
  assign rs2_hazard = (rs2_raddr != '0) &&
                      (pending[rs2_raddr] || (wen && (rd_waddr == rs2_raddr)));
  assign hazard_stall = rs1_hazard || rs2_hazard;

  // Scoreboard next state: retire the head load, then mark the newly issued one.
  always_comb begin
    pending_nxt = pending;
    if (rsp_fire) begin
      pending_nxt[head_rd] = 1'b0;
    end
    if (issue_fire && (ld_issue_rd != '0)) begin
      pending_nxt[ld_issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Load queue entries; contents are don't-care while their slot is empty.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      lq_mem[wr_ptr] <= ld_issue_rd;
    end
  end

  // Load queue pointers and occupancy; x0 loads occupy a slot to keep responses aligned.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue_fire) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rsp_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({issue_fire, rsp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write port register: load response first, execute second, otherwise drop wen and hold address/data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wen      <= 1'b0;
      rd_waddr <= '0;
      rd_wdata <= '0;
    end else if (rsp_fire) begin
      wen      <= (head_rd != '0);
      rd_waddr <= head_rd;
      rd_wdata <= ld_rsp_data;
    end else if (ex_fire) begin
      wen      <= (ex_rd != '0);
      rd_waddr <= ex_rd;
      rd_wdata <= ex_data;
    end else begin
      wen      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// tb/tb_wb_ctrl.sv - directed and random checks of wb_ctrl against a queue-based reference model
module tb_wb_ctrl;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int REGNUM     = 32;
  localparam int LQ_DEPTH   = 2;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0]     ex_data;
  logic                  ex_ready;
  logic                  ld_issue_valid;
  logic [REG_ADDR_W-1:0] ld_issue_rd;
  logic                  ld_issue_ready;
  logic                  ld_rsp_valid;
  logic [DATA_W-1:0]     ld_rsp_data;
  logic                  ld_rsp_ready;
  logic [REG_ADDR_W-1:0] rs1_raddr;
  logic [REG_ADDR_W-1:0] rs2_raddr;
  logic                  hazard_stall;
  logic [REG_ADDR_W-1:0] rd_waddr;
  logic [DATA_W-1:0]     rd_wdata;
  logic                  wen;
  logic [$clog2(LQ_DEPTH):0] lq_count;

  wb_ctrl #(
    .REG_ADDR_W(REG_ADDR_W),
    .DATA_W    (DATA_W),
    .REGNUM    (REGNUM),
    .LQ_DEPTH  (LQ_DEPTH)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_data       (ex_data),
    .ex_ready      (ex_ready),
    .ld_issue_valid(ld_issue_valid),
    .ld_issue_rd   (ld_issue_rd),
    .ld_issue_ready(ld_issue_ready),
    .ld_rsp_valid  (ld_rsp_valid),
    .ld_rsp_data   (ld_rsp_data),
    .ld_rsp_ready  (ld_rsp_ready),
    .rs1_raddr     (rs1_raddr),
    .rs2_raddr     (rs2_raddr),
    .hazard_stall  (hazard_stall),
    .rd_waddr      (rd_waddr),
    .rd_wdata      (rd_wdata),
    .wen           (wen),
    .lq_count      (lq_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding loads in issue order plus the last write presented to the register file.
  int unsigned      q[$];
  logic             m_wen;
  int unsigned      m_waddr;
  logic [31:0]      m_wdata;
  logic             e_issue_rdy;
  logic             e_rsp_rdy;
  logic             e_ex_rdy;

  function automatic bit owed(int unsigned r);
    if (r == 0) return 1'b0;
    foreach (q[i]) if (q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit src_unsafe(int unsigned r);
    return (r != 0) && (owed(r) || (m_wen && (m_waddr == r)));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wen   = 1'b0;
    m_waddr = 0;
    m_wdata = '0;
  endtask

  task automatic drive(input logic exv, input int unsigned exrd, input logic [31:0] exd,
                       input logic iv, input int unsigned ird,
                       input logic rv, input logic [31:0] rdat,
                       input int unsigned s1, input int unsigned s2);
    ex_valid       = exv;
    ex_rd          = REG_ADDR_W'(exrd);
    ex_data        = exd;
    ld_issue_valid = iv;
    ld_issue_rd    = REG_ADDR_W'(ird);
    ld_rsp_valid   = rv;
    ld_rsp_data    = rdat;
    rs1_raddr      = REG_ADDR_W'(s1);
    rs2_raddr      = REG_ADDR_W'(s2);
  endtask

  task automatic idle(input int unsigned s1, input int unsigned s2);
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0, '0, s1, s2);
  endtask

  // One clock: compare everything at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    int unsigned head;
    @(negedge clk);
    e_issue_rdy = (q.size() < LQ_DEPTH) && !owed(ld_issue_rd);
    e_rsp_rdy   = (q.size() != 0);
    e_ex_rdy    = !(ld_rsp_valid && e_rsp_rdy) && !owed(ex_rd);
    chk("ld_issue_ready", ld_issue_ready, e_issue_rdy);
    chk("ld_rsp_ready",   ld_rsp_ready,   e_rsp_rdy);
    chk("ex_ready",       ex_ready,       e_ex_rdy);
    chk("hazard_stall",   hazard_stall,   src_unsafe(rs1_raddr) || src_unsafe(rs2_raddr));
    chk("wen",            wen,            m_wen);
    chk("rd_waddr",       rd_waddr,       m_waddr);
    chk("rd_wdata",       rd_wdata,       m_wdata);
    chk("lq_count",       lq_count,       q.size());
    @(posedge clk);
    if (rstn) begin
      if (ld_rsp_valid && e_rsp_rdy) begin
        head    = q.pop_front();
        m_wen   = (head != 0);
        m_waddr = head;
        m_wdata = ld_rsp_data;
      end else if (ex_valid && e_ex_rdy) begin
        m_wen   = (ex_rd != 0);
        m_waddr = ex_rd;
        m_wdata = ex_data;
      end else begin
        m_wen = 1'b0;
      end
      if (ld_issue_valid && e_issue_rdy) q.push_back(ld_issue_rd);
    end
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    idle(5, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset values while held in reset.
    @(negedge clk);
    chk("rst_wen",          wen,            1'b0);
    chk("rst_waddr",        rd_waddr,       5'd0);
    chk("rst_wdata",        rd_wdata,       32'd0);
    chk("rst_lq_count",     lq_count,       2'd0);
    chk("rst_rsp_ready",    ld_rsp_ready,   1'b0);
    chk("rst_issue_ready",  ld_issue_ready, 1'b1);
    chk("rst_ex_ready",     ex_ready,       1'b1);
    chk("rst_hazard",       hazard_stall,   1'b0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // Execute write to x3 and its one-cycle hazard window.
    drive(1'b1, 3, 32'hDEADBEEF, 1'b0, 0, 1'b0, '0, 3, 0);
    cycle();
    idle(3, 0);
    cycle();
    cycle();

    // Two loads fill the queue, a third is refused, responses retire in order.
    drive(1'b0, 0, '0, 1'b1, 7, 1'b0, '0, 7, 9);
    cycle();
    drive(1'b0, 0, '0, 1'b1, 9, 1'b0, '0, 7, 9);
    cycle();
    drive(1'b0, 0, '0, 1'b1, 11, 1'b0, '0, 7, 9);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 32'h11, 7, 9);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 32'h22, 7, 9);
    cycle();
    idle(7, 9);
    cycle();
    cycle();

    // WAW: execute to x4 waits behind a load to x4, then writes right after it.
    drive(1'b0, 0, '0, 1'b1, 4, 1'b0, '0, 4, 0);
    cycle();
    drive(1'b1, 4, 32'hCAFE0004, 1'b0, 0, 1'b0, '0, 4, 0);
    cycle();
    cycle();
    drive(1'b1, 4, 32'hCAFE0004, 1'b0, 0, 1'b1, 32'h44, 4, 0);
    cycle();
    drive(1'b1, 4, 32'hCAFE0004, 1'b0, 0, 1'b0, '0, 4, 0);
    cycle();
    idle(4, 0);
    cycle();
    chk("waw_exec_addr", rd_waddr, 5'd4);
    chk("waw_exec_data", rd_wdata, 32'hCAFE0004);

    // x0 load and x0 execute: both accepted, nothing written, queue still pops.
    drive(1'b1, 0, 32'h12345678, 1'b1, 0, 1'b0, '0, 0, 0);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 32'h99, 0, 0);
    cycle();
    idle(0, 0);
    cycle();
    chk("x0_wen", wen, 1'b0);

    // Reset with two loads outstanding: queue empties at once, later responses are ignored.
    drive(1'b0, 0, '0, 1'b1, 12, 1'b0, '0, 12, 13);
    cycle();
    drive(1'b0, 0, '0, 1'b1, 13, 1'b0, '0, 12, 13);
    cycle();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("midrst_lq_count",  lq_count,     2'd0);
    chk("midrst_rsp_ready", ld_rsp_ready, 1'b0);
    chk("midrst_wen",       wen,          1'b0);
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 32'h55, 12, 13);
    cycle();
    rstn = 1'b1;
    cycle();
    idle(12, 13);
    cycle();

    // Random traffic over a small register window so conflicts are frequent.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 4) < 2, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 7), $urandom_range(0, 7));
      cycle();
    end
    idle(0, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
